ex_div: RTL and testbench

- Multi-cycle radix-2 restoring divider for the EX stage; serves DIV/DIVU.
- Drives the EX stage's HI/LO write data: remainder goes to HI, quotient goes to LO.
- Raises a stall request that freezes IF..EX while a division runs.
- On completion, the EX/MEM register captures the result with its HI/LO write enable set.

---
 rtl/ex_div.sv | 158 +++++++++++++++
 tb/tb_ex_div.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// Optional `DIV_EARLY_EXIT_EN: finish on the accept edge when |dividend| < |divisor|.
module ex_div #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             annul,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             ready,
   output logic             stall_req
);

   // state | meaning
   // IDLE  | waiting for start; ready low
   // DZERO | divisor was zero; results forced to zero on the next edge
   // RUN   | one restoring iteration per cycle
   // DONE  | results valid, held until start drops or annul
   typedef enum logic [1:0] {IDLE, DZERO, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [WIDTH-1:0] rem, rem_nx;
   logic [WIDTH-1:0] quo, quo_nx;
   logic [WIDTH-1:0] dvs, dvs_nx;
   logic             neg_q, neg_q_nx;
   logic             neg_r, neg_r_nx;
   logic [WIDTH-1:0] lo_nx, hi_nx;
   logic             ready_nx;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] q_step, r_step;

   assign a_neg = signed_div & dividend[WIDTH-1];
   assign b_neg = signed_div & divisor[WIDTH-1];
   assign a_mag = a_neg ? -dividend : dividend;
   assign b_mag = b_neg ? -divisor : divisor;

   // Extra top bit keeps |most-negative| representable during the trial subtract.
   assign shifted = {rem, quo[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs};
   assign q_step  = {quo[WIDTH-2:0], ~trial[WIDTH]};
   assign r_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

   assign stall_req = start & ~ready & ~annul;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rem_nx   = rem;
      quo_nx   = quo;
      dvs_nx   = dvs;
      neg_q_nx = neg_q;
      neg_r_nx = neg_r;
      lo_nx    = result_lo;
      hi_nx    = result_hi;
      ready_nx = ready;
      case (state)
         IDLE: begin
            ready_nx = 1'b0;
            if (start && !annul) begin
               if (divisor == '0) begin
                  state_nx = DZERO;
               end
`ifdef DIV_EARLY_EXIT_EN
               else if (a_mag < b_mag) begin
                  state_nx = DONE;
                  lo_nx    = '0;
                  hi_nx    = dividend;
                  ready_nx = 1'b1;
               end
`endif
               else begin
                  quo_nx   = a_mag;
                  dvs_nx   = b_mag;
                  rem_nx   = '0;
                  cnt_nx   = '0;
                  neg_q_nx = a_neg ^ b_neg;
                  neg_r_nx = a_neg;
                  state_nx = RUN;
               end
            end
         end
         DZERO: begin
            if (annul) begin
               state_nx = IDLE;
               ready_nx = 1'b0;
            end else begin
               state_nx = DONE;
               lo_nx    = '0;
               hi_nx    = '0;
               ready_nx = 1'b1;
            end
         end
         RUN: begin
            if (annul) begin
               state_nx = IDLE;
               ready_nx = 1'b0;
            end else begin
               quo_nx = q_step;
               rem_nx = r_step;
               cnt_nx = cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH-1)) begin
                  state_nx = DONE;
                  lo_nx    = neg_q ? -q_step : q_step;
                  hi_nx    = neg_r ? -r_step : r_step;
                  ready_nx = 1'b1;
               end
            end
         end
         DONE: begin
            if (annul || !start) begin
               state_nx = IDLE;
               ready_nx = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
            ready_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         ready     <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         rem       <= rem_nx;
         quo       <= quo_nx;
         dvs       <= dvs_nx;
         neg_q     <= neg_q_nx;
         neg_r     <= neg_r_nx;
         result_lo <= lo_nx;
         result_hi <= hi_nx;
         ready     <= ready_nx;
      end
   end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, annul/reset sequences, random vs model.
// Latency expectations follow `DIV_EARLY_EXIT_EN when it is defined for the build.
module tb_ex_div;

   logic        clk;
   logic        reset;
   logic        start;
   logic        signed_div;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        annul;
   logic [31:0] result_lo;
   logic [31:0] result_hi;
   logic        ready;
   logic        stall_req;

   int checks   = 0;
   int failures = 0;

   ex_div #(.WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .signed_div (signed_div),
      .dividend   (dividend),
      .divisor    (divisor),
      .annul      (annul),
      .result_lo  (result_lo),
      .result_hi  (result_hi),
      .ready      (ready),
      .stall_req  (stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got=%h want=%h", nm, got, want);
      end
   endtask

   // Reference: language-level truncating division; zero divisor gives zeros.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] lo, output logic [31:0] hi);
      longint sa, sb;
      if (b == 32'd0) begin
         lo = '0;
         hi = '0;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lo = 32'(sa / sb);
         hi = 32'(sa % sb);
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endfunction

   // Edges counted with the accept edge as edge 1.
   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef DIV_EARLY_EXIT_EN
      longint ma, mb;
`endif
      if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
      ma = s ? longint'($signed(a)) : longint'({32'd0, a});
      mb = s ? longint'($signed(b)) : longint'({32'd0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (ma < mb) return 1;
`else
      if (s && a == 32'd0) return 33;
`endif
      return 33;
   endfunction

   task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] elo, input logic [31:0] ehi);
      int lat;
      bit stall_ok;
      @(negedge clk);
      start = 1'b1; signed_div = s; dividend = a; divisor = b;
      #1 stall_ok = (stall_req === 1'b1);
      @(posedge clk); #1;
      lat = 1;
      dividend = $urandom; divisor = $urandom;
      while (ready !== 1'b1 && lat < 60) begin
         if (stall_req !== 1'b1) stall_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, ".lat"}, lat, exp_lat(a, b, s));
      chk({nm, ".stall_busy"}, {31'd0, stall_ok}, 32'd1);
      chk({nm, ".lo"}, result_lo, elo);
      chk({nm, ".hi"}, result_hi, ehi);
      chk({nm, ".stall_ready"}, {31'd0, stall_req}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk({nm, ".hold_ready"}, {31'd0, ready}, 32'd1);
      chk({nm, ".hold_lo"}, result_lo, elo);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk({nm, ".drop_ready"}, {31'd0, ready}, 32'd0);
      chk({nm, ".drop_hi"}, result_hi, ehi);
   endtask

   initial begin
      logic [31:0] lo0, hi0, a, b, elo, ehi;
      logic        s;
      bit          seen;
      int          n;

      vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
      vecs[1]  = '{32'hFFFFFFF9,   32'h2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF};
      vecs[2]  = '{32'h7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'h1};
      vecs[3]  = '{32'h1234,       32'h0,          1'b1, 32'h0,          32'h0};
      vecs[4]  = '{32'h1234,       32'h0,          1'b0, 32'h0,          32'h0};
      vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'h0};
      vecs[6]  = '{32'hFFFFFFFF,   32'h1,          1'b0, 32'hFFFFFFFF,   32'h0};
      vecs[7]  = '{32'd50,         32'd5,          1'b0, 32'd10,         32'd0};
      vecs[8]  = '{32'd3,          32'd9,          1'b0, 32'd0,          32'd3};
      vecs[9]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h1,          32'h0};
      vecs[10] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'h1,          32'h0};
      vecs[11] = '{32'h80000000,   32'h2,          1'b1, 32'hC0000000,   32'h0};
      vecs[12] = '{32'h80000000,   32'h3,          1'b0, 32'h2AAAAAAA,   32'h2};
      vecs[13] = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE};
      vecs[14] = '{32'hFFFFFFFD,   32'd9,          1'b1, 32'h0,          32'hFFFFFFFD};

      reset = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
      dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", {31'd0, ready}, 32'd0);
      chk("rst.lo", result_lo, 32'd0);
      chk("rst.hi", result_hi, 32'd0);
      chk("rst.stall", {31'd0, stall_req}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 15; i++)
         run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].lo, vecs[i].hi);

      // annul during RUN, then annul holding off a pending start in IDLE
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      lo0 = result_lo; hi0 = result_hi;
      annul = 1'b1;
      #1 chk("annul.stall", {31'd0, stall_req}, 32'd0);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ready === 1'b1) seen = 1'b1;
      end
      @(negedge clk);
      annul = 1'b0; start = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready === 1'b1) seen = 1'b1;
      end
      chk("annul.ready_never", {31'd0, seen}, 32'd0);
      chk("annul.lo_kept", result_lo, lo0);
      chk("annul.hi_kept", result_hi, hi0);
      run_div("after_annul", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0);

      // annul while DONE with start still high
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
      n = 0;
      @(posedge clk); #1;
      while (ready !== 1'b1 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_annul.reached", {31'd0, ready}, 32'd1);
      annul = 1'b1;
      @(posedge clk); #1;
      chk("done_annul.ready", {31'd0, ready}, 32'd0);
      chk("done_annul.lo", result_lo, 32'd14);
      chk("done_annul.hi", result_hi, 32'd2);
      @(negedge clk);
      annul = 1'b0; start = 1'b0;

      // async reset between edges mid-RUN
      @(negedge clk);
      start = 1'b1; signed_div = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      repeat (6) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("areset.ready", {31'd0, ready}, 32'd0);
      chk("areset.lo", result_lo, 32'd0);
      chk("areset.hi", result_hi, 32'd0);
      @(negedge clk);
      start = 1'b0; reset = 1'b1;
      run_div("after_reset", 32'd3, 32'd9, 1'b0, 32'd0, 32'd3);

      // random operands against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       a = $urandom_range(0, 200);
            1:       a = 32'h80000000;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFFFFFF;
            3:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         s = 1'($urandom_range(0, 1));
         model(a, b, s, elo, ehi);
         run_div($sformatf("rnd%0d", i), a, b, s, elo, ehi);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
